// File: rtl/seg_scanner_pkg.sv
// Shared display package: scan FSM states and parameter limits
// for the multiplexed 7-segment display blocks.
package seg_scanner_pkg;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_GUARD = 1'b1
  } scan_state_t;

  localparam int DIGITS_MIN = 1;
  localparam int DIGITS_MAX = 8;
  localparam int DIV_MIN    = 2;
  localparam int DIV_MAX    = 65535;
  localparam int GUARD_MIN  = 1;
  localparam int GUARD_MAX  = 255;
  localparam int CNT_W      = 16;

endpackage

// File: rtl/scan_counter.sv
// Cycle counter shared by SHOW and GUARD; the terminal
// count follows the current scan state.
module scan_counter
  import seg_scanner_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  scan_state_t      state,
  input  logic [CNT_W-1:0] tc_show,
  input  logic [CNT_W-1:0] tc_guard,
  output logic             done
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] tc;

  assign tc   = (state == ST_SHOW) ? tc_show : tc_guard;
  assign done = (cnt == tc);

  // done always coincides with a state change, so the
  // next state starts counting from zero
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (done) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/seg_scanner.sv
// Multiplexed 7-segment digit scanner with guard gaps,
// frame-aligned value updates and leading-zero blanking.
module seg_scanner
  import seg_scanner_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int DIV    = 1000,
  parameter int GUARD  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  lz_blank,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [CNT_W-1:0] TC_SHOW  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] TC_GUARD = CNT_W'(GUARD - 1);

  scan_state_t         state, state_n;
  logic [IW-1:0]       idx, idx_n;
  logic [4*DIGITS-1:0] shadow, shadow_n;
  logic [4*DIGITS-1:0] pending;
  logic                pend_v;
  logic                done;
  logic                boundary;
  logic [4*DIGITS-1:0] upper;
  logic                blank_n;
  logic [3:0]          nib_n;
  logic [DIGITS-1:0]   en_n;

  scan_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .state    (state),
    .tc_show  (TC_SHOW),
    .tc_guard (TC_GUARD),
    .done     (done)
  );

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    boundary = 1'b0;
    unique case (state)
      ST_SHOW: begin
        if (done) state_n = ST_GUARD;
      end
      ST_GUARD: begin
        if (done) begin
          state_n  = ST_SHOW;
          boundary = (idx == LAST);
          idx_n    = (idx == LAST) ? '0 : idx + 1'b1;
        end
      end
    endcase
  end

  // new word only at the frame boundary; a boundary load beats pending
  always_comb begin
    shadow_n = shadow;
    if (boundary) begin
      if (load)        shadow_n = value;
      else if (pend_v) shadow_n = pending;
    end
  end

  // outputs are registered from the upcoming digit so they line up
  // with the state the scanner is entering
  always_comb begin
    upper   = shadow_n >> {idx_n, 2'b00};
    nib_n   = shadow_n[{idx_n, 2'b00} +: 4];
    blank_n = lz_blank && (idx_n != '0) && (upper == '0);
    en_n    = '0;
    for (int k = 0; k < DIGITS; k++)
      en_n[k] = (idx_n == IW'(k));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_GUARD;
      idx      <= LAST;
      shadow   <= '0;
      pending  <= '0;
      pend_v   <= 1'b0;
      nibble   <= '0;
      digit_en <= '0;
      frame    <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      shadow <= shadow_n;
      frame  <= boundary;
      if (boundary) begin
        pend_v <= 1'b0;
      end else if (load) begin
        pending <= value;
        pend_v  <= 1'b1;
      end
      if (state_n == ST_SHOW) begin
        nibble   <= nib_n;
        digit_en <= blank_n ? '0 : en_n;
      end else begin
        digit_en <= '0;
      end
    end
  end

endmodule

// File: doc/seg_scanner.md
SEG_SCANNER -- requirements
Module: seg_scanner

Interface
REQ-001 Parameter DIGITS, default 2: number of multiplexed 7-segment digits, legal range 1..8.
REQ-002 Parameter DIV, default 1000: clock cycles each digit is driven, legal range 2..65535.
REQ-003 Parameter GUARD, default 4: all-digits-off cycles between digits (anti-ghosting), legal range 1..255.
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port value, input, 4*DIGITS: hex word to display; nibble k maps to digit k, and digit 0 is least significant.
REQ-007 Port load, input, 1: single-cycle strobe that captures value.
REQ-008 Port lz_blank, input, 1: when high, leading zero digits are suppressed.
REQ-009 Port nibble, output, 4: current digit nibble, fed to the nibble-to-segment decoder.
REQ-010 Port digit_en, output, DIGITS: one-hot active-high digit enable; all zero while blanked or in guard.
REQ-011 Port frame, output, 1: one-cycle pulse on the first cycle of each new frame (digit 0 entry).

Function
REQ-012 The block SHALL hold an FSM with two states: SHOW (a digit is driven) and GUARD (all digits off).
REQ-013 SHOW SHALL last exactly DIV cycles (counter 0..DIV-1), then transition to GUARD.
REQ-014 GUARD SHALL last exactly GUARD cycles, then transition to SHOW with idx advanced (DIGITS-1 wraps to 0).
REQ-015 In SHOW, nibble SHALL equal shadow[4*idx+3:4*idx]; in GUARD, nibble SHALL hold its last value.
REQ-016 In SHOW, digit_en SHALL equal 1<<idx unless the digit is blanked; in GUARD, digit_en SHALL be all zero.
REQ-017 Digit idx SHALL be blanked when lz_blank=1, idx>0, and every shadow nibble at index >= idx is zero; digit 0 is never blanked.
REQ-018 A load SHALL write value to a pending register and set pending_valid; a later load before the frame boundary overwrites it (latest wins).
REQ-019 At the GUARD-to-SHOW transition where idx wraps to 0 (the frame boundary), shadow SHALL take value if load=1 that cycle, else pending if pending_valid=1; pending_valid then clears.
REQ-020 The shadow register SHALL change only at a frame boundary, so a frame never mixes old and new digits.
REQ-021 frame SHALL be asserted in the first SHOW cycle of digit 0, one cycle after the boundary update, and shall coincide with the new shadow.
REQ-022 A lz_blank change SHALL take effect on the next SHOW cycle without frame alignment.
REQ-023 For DIGITS=1, idx SHALL stay 0 and every GUARD exit SHALL be a frame boundary.

Reset
REQ-024 On rst=1: state=GUARD, guard counter=0, idx=DIGITS-1, shadow=0, pending=0, pending_valid=0, nibble=0, digit_en=0, frame=0.
REQ-025 After rst deasserts, the first frame SHALL start after GUARD cycles; rst mid-frame SHALL abort the current digit immediately.
REQ-026 A load asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-027 State encoding and parameter range constants SHALL live in a shared display package used by the display blocks.
REQ-028 The cycle counter (shared by SHOW and GUARD) SHALL be a sub-module named scan_counter, with terminal count selectable per state.
REQ-029 The block SHALL contain no segment decoding; the top level wires nibble to the existing nibble-to-segment decoder.

Verification (DIGITS=2, DIV=4, GUARD=1)
REQ-030 Scenario: reset, load value=8'h3A -> frame pulse; digit_en=01 with nibble=A for 4 cycles; 00 for 1 cycle; 10 with nibble=3 for 4 cycles; 00 for 1 cycle; period 10 cycles.
REQ-031 Scenario: lz_blank=1, value=8'h05 -> digit 1 slot has digit_en=00 and nibble=0; digit 0 shows 5; value=8'h00 -> digit 0 still shows 0.
REQ-032 Scenario: load 8'h12 mid-frame, then load 8'h34 before the boundary -> the next frame shows 3 and 4 only, and 2 and 1 never appear.
REQ-033 Scenario: load 8'h77 exactly on the boundary cycle -> the immediately following frame shows 7 and 7.
REQ-034 Scenario: rst asserted during digit 1 SHOW -> the next cycle has digit_en=00 and nibble=0; recovery matches the first scenario timing.
REQ-035 Scenario: in every scenario, assert that digit_en is never multi-hot and that at least one zero cycle separates any two different one-hot digit_en values.
